// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD integer ALU: LANES lanes of LANE_W-bit operands, 2*LANE_W-bit results.
// S1 registers the operand beat; S2 computes, updates per-lane accumulators and registers the result.
module simd_alu_pipe #(
    parameter int LANES  = 16,
    parameter int LANE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [LANES*LANE_W-1:0]   in_a,
    input  logic [LANES*LANE_W-1:0]   in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_lo,
    output logic [LANES*LANE_W-1:0]   out_hi,
    output logic [LANES-1:0]          out_ovf
);

    localparam int RW = 2 * LANE_W;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_MAC  = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    logic                    vld_p1_q;
    logic                    vld_p2_q;
    logic [2:0]              op_p1_q;
    logic [LANES*LANE_W-1:0] a_p1_q;
    logic [LANES*LANE_W-1:0] b_p1_q;

    logic [RW-1:0]           acc_q [LANES];
    logic [RW-1:0]           acc_d [LANES];
    logic [RW-1:0]           res_d [LANES];
    logic [LANES*LANE_W-1:0] lo_d;
    logic [LANES*LANE_W-1:0] hi_d;
    logic [LANES-1:0]        ovf_d;

    logic s1_en;
    logic s2_en;

    function automatic logic signed [RW-1:0] sext(input logic [LANE_W-1:0] x);
        return {{LANE_W{x[LANE_W-1]}}, x};
    endfunction

    // A sum/difference of two sign-extended operands fits LANE_W iff its upper half mirrors bit LANE_W-1.
    function automatic logic add_ovf(input logic signed [RW-1:0] r);
        return r != sext(r[LANE_W-1:0]);
    endfunction

    function automatic logic [RW-1:0] lane_res(input logic [2:0]        op,
                                               input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b,
                                               input logic [RW-1:0]     acc);
        logic signed [RW-1:0] sa;
        logic signed [RW-1:0] sb;
        logic        [RW-1:0] ua;
        logic        [RW-1:0] ub;
        logic        [RW-1:0] sprod;
        sa    = sext(a);
        sb    = sext(b);
        ua    = {{LANE_W{1'b0}}, a};
        ub    = {{LANE_W{1'b0}}, b};
        sprod = sa * sb;
        case (op)
            OP_MUL:  return sprod;
            OP_MULU: return ua * ub;
            OP_ADD:  return sa + sb;
            OP_SUB:  return sa - sb;
            OP_MAC:  return acc + sprod;
            default: return '0;
        endcase
    endfunction

    assign s2_en     = !vld_p2_q || out_ready;
    assign s1_en     = !vld_p1_q || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = vld_p2_q;

    always_comb begin
        lo_d  = '0;
        hi_d  = '0;
        ovf_d = '0;
        for (int i = 0; i < LANES; i++) begin
            res_d[i] = lane_res(op_p1_q, a_p1_q[i*LANE_W +: LANE_W],
                                b_p1_q[i*LANE_W +: LANE_W], acc_q[i]);
            lo_d[i*LANE_W +: LANE_W] = res_d[i][LANE_W-1:0];
            hi_d[i*LANE_W +: LANE_W] = res_d[i][RW-1:LANE_W];
            ovf_d[i] = ((op_p1_q == OP_ADD) || (op_p1_q == OP_SUB)) && add_ovf(res_d[i]);
            acc_d[i] = ((op_p1_q == OP_MAC) || (op_p1_q == OP_CLR)) ? res_d[i] : acc_q[i];
        end
    end

    // ---- S1: operand capture ----
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            op_p1_q <= in_op;
            a_p1_q  <= in_a;
            b_p1_q  <= in_b;
        end
    end

    // ---- S1 -> S2: result and accumulator registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            out_lo   <= '0;
            out_hi   <= '0;
            out_ovf  <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (s1_en) begin
                vld_p1_q <= in_valid;
            end
            if (s2_en) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    out_lo  <= lo_d;
                    out_hi  <= hi_d;
                    out_ovf <= ovf_d;
                    for (int i = 0; i < LANES; i++) begin
                        acc_q[i] <= acc_d[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe: lane-level arithmetic model plus scoreboard,
// with literal expectations for the hand-worked scenarios.
module tb_simd_alu_pipe;
    localparam int L  = 16;
    localparam int W  = 32;
    localparam int VW = L * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [VW-1:0] in_a;
    logic [VW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_lo;
    logic [VW-1:0] out_hi;
    logic [L-1:0]  out_ovf;

    simd_alu_pipe #(.LANES(L), .LANE_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] lo;
        logic [VW-1:0] hi;
        logic [L-1:0]  ovf;
    } beat_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    beat_t         expq[$];
    longint        macc[L];
    logic [VW-1:0] log_lo[$];
    logic [VW-1:0] log_hi[$];
    logic [L-1:0]  log_ovf[$];
    int            log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ln(input logic [VW-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // Operand vector: pseudo-varied filler in every lane, value v forced into lane idx.
    function automatic logic [VW-1:0] mk(input int idx, input logic [31:0] v, input int seed);
        logic [VW-1:0] x;
        for (int i = 0; i < L; i++)
            x[i*W +: W] = 32'(seed) ^ (32'(i + 1) * 32'h9E3779B9);
        x[idx*W +: W] = v;
        return x;
    endfunction

    // Reference: plain 64-bit integer arithmetic per lane, accumulators advanced in issue order.
    function automatic beat_t model(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
        beat_t       e;
        logic [31:0] a32;
        logic [31:0] b32;
        longint      sa;
        longint      sb;
        longint      r;
        longint      lim;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] rb;
        lim = 64'sd2147483647;
        for (int i = 0; i < L; i++) begin
            a32 = a[i*W +: W];
            b32 = b[i*W +: W];
            sa  = $signed(a32);
            sb  = $signed(b32);
            ua  = {32'd0, a32};
            ub  = {32'd0, b32};
            e.ovf[i] = 1'b0;
            case (op)
                3'd0: r = sa * sb;
                3'd1: begin r = sa + sb; e.ovf[i] = (r > lim) || (r < -lim - 1); end
                3'd2: begin r = sa - sb; e.ovf[i] = (r > lim) || (r < -lim - 1); end
                3'd3: r = longint'(ua * ub);
                3'd4: begin macc[i] = macc[i] + sa * sb; r = macc[i]; end
                3'd5: begin macc[i] = 0; r = 0; end
                default: r = 0;
            endcase
            rb = r;
            e.lo[i*W +: W] = rb[31:0];
            e.hi[i*W +: W] = rb[63:32];
        end
        return e;
    endfunction

    logic          stall_prev = 1'b0;
    logic [VW-1:0] plo;
    logic [VW-1:0] phi;
    logic [L-1:0]  povf;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            expq.delete();
            for (int i = 0; i < L; i++) macc[i] = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid)
                chk("hold_stable", 64'({out_lo, out_hi, out_ovf} === {plo, phi, povf}), 64'd1);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    for (int i = 0; i < L; i++) begin
                        chk($sformatf("lo[%0d]", i), 64'(ln(out_lo, i)), 64'(ln(e.lo, i)));
                        chk($sformatf("hi[%0d]", i), 64'(ln(out_hi, i)), 64'(ln(e.hi, i)));
                    end
                    chk("ovf", 64'(out_ovf), 64'(e.ovf));
                end
                log_lo.push_back(out_lo);
                log_hi.push_back(out_hi);
                log_ovf.push_back(out_ovf);
                log_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) expq.push_back(model(in_op, in_a, in_b));
            stall_prev = out_valid && !out_ready;
            plo = out_lo;
            phi = out_hi;
            povf = out_ovf;
        end
    end

    task automatic clear_log();
        log_lo.delete();
        log_hi.delete();
        log_ovf.delete();
        log_cyc.delete();
    endtask

    task automatic set_in(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic beat(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        set_in(op, a, b);
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  acc_n;
        int  n;
        bit  got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid_rel", 64'(out_valid), 64'd0);
        chk("rst_out_zero", 64'((out_lo == '0) && (out_hi == '0) && (out_ovf == '0)), 64'd1);

        // MUL latency and signed product
        clear_log();
        beat(3'd0, mk(0, 32'hFFFFFFFF, 1), mk(0, 32'd2, 2));
        chk("t1_valid_c1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_c2", 64'(out_valid), 64'd1);
        chk("t1_hi", 64'(ln(out_hi, 0)), 64'hFFFFFFFF);
        chk("t1_lo", 64'(ln(out_lo, 0)), 64'hFFFFFFFE);
        chk("t1_ovf", 64'(out_ovf[0]), 64'd0);
        drain();

        // MULU
        clear_log();
        beat(3'd3, mk(0, 32'hFFFFFFFF, 1), mk(0, 32'd2, 2));
        drain();
        chk("t2_hi", 64'(ln(log_hi[0], 0)), 64'h1);
        chk("t2_lo", 64'(ln(log_lo[0], 0)), 64'hFFFFFFFE);

        // ADD/SUB overflow on lane 3
        clear_log();
        beat(3'd1, mk(3, 32'h7FFFFFFF, 3), mk(3, 32'd1, 4));
        beat(3'd2, mk(3, 32'h80000000, 5), mk(3, 32'd1, 6));
        drain();
        chk("t3_add_lo", 64'(ln(log_lo[0], 3)), 64'h80000000);
        chk("t3_add_hi", 64'(ln(log_hi[0], 3)), 64'h0);
        chk("t3_add_ovf", 64'(log_ovf[0][3]), 64'd1);
        chk("t3_sub_lo", 64'(ln(log_lo[1], 3)), 64'h7FFFFFFF);
        chk("t3_sub_hi", 64'(ln(log_hi[1], 3)), 64'hFFFFFFFF);
        chk("t3_sub_ovf", 64'(log_ovf[1][3]), 64'd1);

        // CLR then chained MACs, back to back
        clear_log();
        beat(3'd5, mk(0, 32'd0, 7), mk(0, 32'd0, 8));
        beat(3'd4, mk(0, 32'd3, 9), mk(0, 32'd4, 10));
        beat(3'd4, mk(0, 32'hFFFFFFFF, 11), mk(0, 32'd5, 12));
        drain();
        chk("t4_r0", 64'(ln(log_lo[0], 0)), 64'd0);
        chk("t4_r1", 64'(ln(log_lo[1], 0)), 64'd12);
        chk("t4_r2", 64'(ln(log_lo[2], 0)), 64'd7);
        chk("t4_r2_hi", 64'(ln(log_hi[2], 0)), 64'd0);
        chk("t4_gap1", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
        chk("t4_gap2", 64'(log_cyc[2] - log_cyc[1]), 64'd1);

        // Backpressure: 4 ADD beats with out_ready low
        clear_log();
        out_ready = 1'b0;
        acc_n = 0;
        set_in(3'd1, mk(0, 32'd10, 20), mk(0, 32'd1, 30));
        repeat (4) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                acc_n++;
                if (acc_n < 4) set_in(3'd1, mk(0, 32'(10 * (acc_n + 1)), 20 + acc_n), mk(0, 32'd1, 30 + acc_n));
                else in_valid = 1'b0;
            end
        end
        chk("t5_accepted", 64'(acc_n), 64'd2);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_head_lo", 64'(ln(out_lo, 0)), 64'd11);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_head_held", 64'(ln(out_lo, 0)), 64'd11);
        out_ready = 1'b1;
        n = 0;
        while (acc_n < 4 && n < 20) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (got) begin
                acc_n++;
                if (acc_n < 4) set_in(3'd1, mk(0, 32'(10 * (acc_n + 1)), 20 + acc_n), mk(0, 32'd1, 30 + acc_n));
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        drain();
        chk("t5_count", 64'(log_lo.size()), 64'd4);
        if (log_lo.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("t5_order%0d", k), 64'(ln(log_lo[k], 0)), 64'(10 * (k + 1) + 1));
            for (int k = 1; k < 4; k++)
                chk($sformatf("t5_gap%0d", k), 64'(log_cyc[k] - log_cyc[k-1]), 64'd1);
        end

        // Reset with beats in flight and acc=12
        clear_log();
        beat(3'd5, mk(0, 32'd0, 40), mk(0, 32'd0, 41));
        beat(3'd4, mk(0, 32'd3, 42), mk(0, 32'd4, 43));
        drain();
        chk("t6_acc12", 64'(ln(log_lo[1], 0)), 64'd12);
        out_ready = 1'b0;
        beat(3'd4, mk(0, 32'd2, 44), mk(0, 32'd2, 45));
        beat(3'd4, mk(0, 32'd2, 46), mk(0, 32'd2, 47));
        chk("t6_inflight", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_lo", 64'(out_lo == '0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        beat(3'd4, mk(0, 32'd1, 48), mk(0, 32'd1, 49));
        drain();
        chk("t6_post_lo", 64'(ln(log_lo[0], 0)), 64'd1);
        chk("t6_post_hi", 64'(ln(log_hi[0], 0)), 64'd0);
        chk("t6_post_count", 64'(log_lo.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
